fetch_queue: RTL and testbench

Parametrised instruction fetch queue between `instr_fetch` and `decode`, replacing the single-entry, never-stalled `if_id` register with a DEPTH-entry FIFO. It carries {pc, instr, prdt_taken} per entry and uses valid/ready handshakes on both sides, so fetch can run ahead while decode stalls. A single-cycle flush from EX (`ex_pipe_flush`) discards all queued entries.

---
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue.sv | 86 ++++++++
 tb/tb_fetch_queue.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: enqueue/dequeue handshake bundle between instruction fetch and decode.
// Ports (by modport):
//   slave  (the queue)   : in  enq_valid_i, enq_pc_i, enq_instr_i, enq_prdt_taken_i, deq_ready_i
//                          out enq_ready_o, deq_valid_o, deq_pc_o, deq_instr_o, deq_prdt_taken_o
//   master (fetch/decode): the mirror image of slave
interface fetch_queue_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   enq_valid_i;
  logic                   enq_ready_o;
  logic [PC_WIDTH-1:0]    enq_pc_i;
  logic [INSTR_WIDTH-1:0] enq_instr_i;
  logic                   enq_prdt_taken_i;
  logic                   deq_valid_o;
  logic                   deq_ready_i;
  logic [PC_WIDTH-1:0]    deq_pc_o;
  logic [INSTR_WIDTH-1:0] deq_instr_o;
  logic                   deq_prdt_taken_o;

  modport slave (
    input  enq_valid_i, enq_pc_i, enq_instr_i, enq_prdt_taken_i, deq_ready_i,
    output enq_ready_o, deq_valid_o, deq_pc_o, deq_instr_o, deq_prdt_taken_o
  );

  modport master (
    output enq_valid_i, enq_pc_i, enq_instr_i, enq_prdt_taken_i, deq_ready_i,
    input  enq_ready_o, deq_valid_o, deq_pc_o, deq_instr_o, deq_prdt_taken_o
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of {pc, instr, prdt_taken} between fetch and decode.
// Ports:
//   clk, rst      : core clock, asynchronous active-high reset
//   flush_i       : empties the queue at the next edge, overriding enq/deq
//   q (slave)     : enq/deq valid-ready handshakes and entry payload
//   count_o       : number of valid entries, 0..DEPTH
//   almost_full_o : count_o >= DEPTH-1
module fetch_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  fetch_queue_if.slave           q,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   almost_full_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PC_WIDTH-1:0]    pc_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
  logic                   taken_q [DEPTH];

  logic full, empty, enq_fire, deq_fire;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign enq_fire = q.enq_valid_i && !full;
  assign deq_fire = q.deq_ready_i && !empty;

  // Status depends only on registered pointers, never on flush_i or deq_ready_i.
  assign q.enq_ready_o  = !full;
  assign q.deq_valid_o  = !empty;
  assign count_o        = wr_ptr_q - rd_ptr_q;
  assign almost_full_o  = (count_o >= PW'(DEPTH - 1));

  // Head is read straight from the array; stale when empty.
  assign q.deq_pc_o         = pc_q[rd_ptr_q[AW-1:0]];
  assign q.deq_instr_o      = instr_q[rd_ptr_q[AW-1:0]];
  assign q.deq_prdt_taken_o = taken_q[rd_ptr_q[AW-1:0]];

  // Pointer next state; flush overrides both handshakes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; flush leaves contents in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
        taken_q[i] <= 1'b0;
      end
    end else if (enq_fire && !flush_i) begin
      pc_q[wr_ptr_q[AW-1:0]]    <= q.enq_pc_i;
      instr_q[wr_ptr_q[AW-1:0]] <= q.enq_instr_i;
      taken_q[wr_ptr_q[AW-1:0]] <= q.enq_prdt_taken_i;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus for fetch_queue checked against
// a queue-based model of FIFO behaviour.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pt;
  } ent_t;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       almost_full;

  fetch_queue_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .q             (bus),
    .count_o       (count),
    .almost_full_o (almost_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   checks   = 0;
  int   failures = 0;
  ent_t mdl[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = mdl.size();
    chk("count", 64'(count), 64'(n));
    chk("deq_valid", 64'(bus.deq_valid_o), 64'(n != 0));
    chk("enq_ready", 64'(bus.enq_ready_o), 64'(n != int'(DEPTH)));
    chk("almost_full", 64'(almost_full), 64'(n >= int'(DEPTH) - 1));
    if (n != 0) begin
      chk("head_pc", 64'(bus.deq_pc_o), 64'(mdl[0].pc));
      chk("head_instr", 64'(bus.deq_instr_o), 64'(mdl[0].instr));
      chk("head_pt", 64'(bus.deq_prdt_taken_o), 64'(mdl[0].pt));
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'hA5C3_0F13;
  endfunction

  // One clock: drive inputs, apply the FIFO rules to the model, compare after the edge.
  task automatic step(input logic ev, input logic [31:0] pc, input logic [31:0] ins,
                      input logic pt, input logic dr, input logic fl);
    logic en, de;
    ent_t e;
    bus.enq_valid_i      = ev;
    bus.enq_pc_i         = pc;
    bus.enq_instr_i      = ins;
    bus.enq_prdt_taken_i = pt;
    bus.deq_ready_i      = dr;
    flush                = fl;
    en = ev && (mdl.size() < int'(DEPTH)) && !fl;
    de = dr && (mdl.size() > 0) && !fl;
    e.pc = pc; e.instr = ins; e.pt = pt;
    @(posedge clk);
    #1;
    if (fl) mdl.delete();
    else begin
      if (de) void'(mdl.pop_front());
      if (en) mdl.push_back(e);
    end
    check_all();
  endtask

  task automatic enq(input logic [31:0] pc, input logic dr);
    step(1'b1, pc, ins_of(pc), pc[2], dr, 1'b0);
  endtask

  task automatic idle(input logic dr);
    step(1'b0, 32'h0, 32'h0, 1'b0, dr, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.enq_valid_i = 1'b0;
    bus.enq_pc_i = '0;
    bus.enq_instr_i = '0;
    bus.enq_prdt_taken_i = 1'b0;
    bus.deq_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 64'(bus.deq_pc_o), 64'h0);
    chk("rst_instr", 64'(bus.deq_instr_o), 64'h0);
    chk("rst_pt", 64'(bus.deq_prdt_taken_o), 64'h0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill, then offer a fifth entry that must be refused.
    for (int k = 0; k < 4; k++) enq(32'(4 * k), 1'b0);
    chk("full_count", 64'(count), 64'd4);
    enq(32'h10, 1'b0);
    chk("fifth_rejected", 64'(count), 64'd4);

    // Drain in order.
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", 64'(bus.deq_pc_o), 64'(4 * k));
      idle(1'b1);
    end
    chk("drained_valid", 64'(bus.deq_valid_o), 64'd0);

    // Stream 20 entries at occupancy 1.
    enq(32'h100, 1'b0);
    for (int k = 1; k < 20; k++) begin
      enq(32'h100 + 32'(4 * k), 1'b1);
      chk("stream_count", 64'(count), 64'd1);
    end
    idle(1'b1);

    // Flush with concurrent enq/deq.
    for (int k = 0; k < 3; k++) enq(32'h180 + 32'(4 * k), 1'b0);
    step(1'b1, 32'h200, ins_of(32'h200), 1'b0, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    enq(32'h300, 1'b0);
    chk("post_flush_pc", 64'(bus.deq_pc_o), 64'h300);
    idle(1'b1);

    // Full with simultaneous dequeue: only the dequeue fires.
    for (int k = 0; k < 4; k++) enq(32'h400 + 32'(4 * k), 1'b0);
    enq(32'h440, 1'b1);
    chk("full_deq_count", 64'(count), 64'd3);
    enq(32'h440, 1'b0);
    chk("retry_count", 64'(count), 64'd4);
    for (int k = 0; k < 4; k++) idle(1'b1);

    // Asynchronous reset pulse between edges.
    enq(32'h500, 1'b0);
    enq(32'h504, 1'b0);
    bus.enq_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    mdl.delete();
    chk("arst_valid", 64'(bus.deq_valid_o), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_pc", 64'(bus.deq_pc_o), 64'h0);
    chk("arst_ready", 64'(bus.enq_ready_o), 64'd1);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    enq(32'h600, 1'b0);
    chk("resume_pc", 64'(bus.deq_pc_o), 64'h600);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] pc;
      pc = $urandom;
      step(1'($urandom_range(0, 1)), pc, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
